// File: rtl/llrf_init_seq.sv
// llrf_init_seq
//   Brings up the DDS clock and sync enables, then replays an N_WR-entry list
//   of AXI4-Lite writes into the AFE control space. The first write is aligned
//   to the DDS sync strobe. Each write has a response timeout and a bounded
//   number of retries. A second FSM tracks the AFE/link/DC-coarse/sync-event
//   bring-up status.
//
// Ports
//   clk, rst                   system clock, synchronous active-high reset
//   mode                       1 = LLRF mode; 0 parks both FSMs
//   sync, sync_ev_p            DDS sync strobe, sync event pulse
//   afe_ready, link_ok,
//   dc_coarse_done             AFE status levels
//   seq_addr, seq_data         packed write list, entry i at [i*AW +: AW] / [i*DW +: DW]
//   dds_clk_ena, dds_sync_ena  sticky DDS enables
//   init_done, init_err        list complete / an entry ran out of retries
//   err_cnt                    saturating count of failed write attempts
//   sync_done                  status FSM has reached SYNC_DONE
//   afe_*                      AXI4-Lite master, write channels only
module llrf_init_seq #(
    parameter int unsigned N_WR      = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 sync,
    input  logic                 sync_ev_p,
    input  logic                 afe_ready,
    input  logic                 link_ok,
    input  logic                 dc_coarse_done,
    input  logic [N_WR*AW-1:0]   seq_addr,
    input  logic [N_WR*DW-1:0]   seq_data,
    output logic                 dds_clk_ena,
    output logic                 dds_sync_ena,
    output logic                 init_done,
    output logic                 init_err,
    output logic [15:0]          err_cnt,
    output logic                 sync_done,
    output logic [AW-1:0]        afe_awaddr,
    output logic                 afe_awvalid,
    input  logic                 afe_awready,
    output logic [DW-1:0]        afe_wdata,
    output logic [DW/8-1:0]      afe_wstrb,
    output logic                 afe_wvalid,
    input  logic                 afe_wready,
    input  logic [1:0]           afe_bresp,
    input  logic                 afe_bvalid,
    output logic                 afe_bready,
    output logic                 afe_arvalid
);

    localparam int unsigned IW = (N_WR > 1) ? $clog2(N_WR) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ENA_DDS_CLK, S_ENA_DDS_SYNC, S_WAIT_AFE,
        S_ISSUE, S_WAIT_RESP, S_DONE, S_ERROR
    } init_state_t;

    typedef enum logic [2:0] {
        ST_AFE_RESET, ST_AFE_READY, ST_LINK_OK, ST_DC_COARSE_DONE, ST_SYNC_DONE
    } stat_state_t;

    init_state_t     init_st_q, init_st_d;
    stat_state_t     stat_st_q, stat_st_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            dds_clk_ena_q, dds_clk_ena_d, dds_sync_ena_q, dds_sync_ena_d;
    logic            init_done_q, init_done_d, init_err_q, init_err_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            sync_done_q, sync_done_d;

    logic            b_hs, tmo_hit, last_ent;

    assign b_hs     = bready_q & afe_bvalid;
    assign tmo_hit  = (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign last_ent = (idx_q == IW'(N_WR - 1));

    always_comb begin
        init_st_d      = init_st_q;
        idx_d          = idx_q;
        retry_d        = retry_q;
        tmo_cnt_d      = tmo_cnt_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        bready_d       = bready_q;
        awaddr_d       = awaddr_q;
        wdata_d        = wdata_q;
        dds_clk_ena_d  = dds_clk_ena_q;
        dds_sync_ena_d = dds_sync_ena_q;
        err_cnt_d      = err_cnt_q;

        case (init_st_q)
            S_IDLE: begin
                if (mode) init_st_d = S_ENA_DDS_CLK;
            end
            S_ENA_DDS_CLK: begin
                dds_clk_ena_d = 1'b1;
                init_st_d     = S_ENA_DDS_SYNC;
            end
            S_ENA_DDS_SYNC: begin
                dds_sync_ena_d = 1'b1;
                init_st_d      = S_WAIT_AFE;
            end
            S_WAIT_AFE: begin
                idx_d   = '0;
                retry_d = '0;
                if (sync && afe_ready) init_st_d = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                if (!afe_ready) begin
                    init_st_d = S_WAIT_AFE;
                end else if (idx_q != '0 || sync) begin
                    // only entry 0 is held off until a sync strobe
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    bready_d  = 1'b1;
                    awaddr_d  = seq_addr[idx_q*AW +: AW];
                    wdata_d   = seq_data[idx_q*DW +: DW];
                    init_st_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (awvalid_q && afe_awready) awvalid_d = 1'b0;
                if (wvalid_q && afe_wready)   wvalid_d  = 1'b0;
                if (!afe_ready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    init_st_d = S_WAIT_AFE;
                end else if (b_hs && afe_bresp == 2'b00) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    retry_d   = '0;
                    if (last_ent) begin
                        init_st_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + IW'(1);
                        init_st_d = S_ISSUE;
                    end
                end else if (b_hs || tmo_hit) begin
                    // error response, or timeout with no handshake this cycle
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d   = retry_q + RW'(1);
                        init_st_d = S_ISSUE;
                    end else begin
                        init_st_d = S_ERROR;
                    end
                end
            end
            S_DONE: begin
                if (!afe_ready) init_st_d = S_WAIT_AFE;
            end
            S_ERROR: begin
            end
            default: init_st_d = S_IDLE;
        endcase

        if (!mode) begin
            init_st_d      = S_IDLE;
            dds_clk_ena_d  = 1'b0;
            dds_sync_ena_d = 1'b0;
            awvalid_d      = 1'b0;
            wvalid_d       = 1'b0;
            bready_d       = 1'b0;
        end

        init_done_d = (init_st_q == S_DONE) && mode && afe_ready;
        init_err_d  = (init_st_q == S_ERROR) && mode;
    end

    always_comb begin
        stat_st_d = stat_st_q;
        case (stat_st_q)
            ST_AFE_RESET:      if (afe_ready)      stat_st_d = ST_AFE_READY;
            ST_AFE_READY:      if (link_ok)        stat_st_d = ST_LINK_OK;
            ST_LINK_OK:        if (dc_coarse_done) stat_st_d = ST_DC_COARSE_DONE;
            ST_DC_COARSE_DONE: if (sync_ev_p)      stat_st_d = ST_SYNC_DONE;
            ST_SYNC_DONE:      stat_st_d = ST_SYNC_DONE;
            default:           stat_st_d = ST_AFE_RESET;
        endcase

        // falls back to the deepest level still satisfied
        if (!mode || !afe_ready) begin
            stat_st_d = ST_AFE_RESET;
        end else if (!link_ok && stat_st_q != ST_AFE_RESET) begin
            stat_st_d = ST_AFE_READY;
        end else if (!dc_coarse_done &&
                     (stat_st_q == ST_DC_COARSE_DONE || stat_st_q == ST_SYNC_DONE)) begin
            stat_st_d = ST_LINK_OK;
        end

        sync_done_d = (stat_st_d == ST_SYNC_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_st_q      <= S_IDLE;
            stat_st_q      <= ST_AFE_RESET;
            idx_q          <= '0;
            retry_q        <= '0;
            tmo_cnt_q      <= '0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            bready_q       <= 1'b0;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            dds_clk_ena_q  <= 1'b0;
            dds_sync_ena_q <= 1'b0;
            init_done_q    <= 1'b0;
            init_err_q     <= 1'b0;
            err_cnt_q      <= '0;
            sync_done_q    <= 1'b0;
        end else begin
            init_st_q      <= init_st_d;
            stat_st_q      <= stat_st_d;
            idx_q          <= idx_d;
            retry_q        <= retry_d;
            tmo_cnt_q      <= tmo_cnt_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            bready_q       <= bready_d;
            awaddr_q       <= awaddr_d;
            wdata_q        <= wdata_d;
            dds_clk_ena_q  <= dds_clk_ena_d;
            dds_sync_ena_q <= dds_sync_ena_d;
            init_done_q    <= init_done_d;
            init_err_q     <= init_err_d;
            err_cnt_q      <= err_cnt_d;
            sync_done_q    <= sync_done_d;
        end
    end

    assign dds_clk_ena  = dds_clk_ena_q;
    assign dds_sync_ena = dds_sync_ena_q;
    assign init_done    = init_done_q;
    assign init_err     = init_err_q;
    assign err_cnt      = err_cnt_q;
    assign sync_done    = sync_done_q;
    assign afe_awaddr   = awaddr_q;
    assign afe_awvalid  = awvalid_q;
    assign afe_wdata    = wdata_q;
    assign afe_wstrb    = '1;
    assign afe_wvalid   = wvalid_q;
    assign afe_bready   = bready_q;
    assign afe_arvalid  = 1'b0;

endmodule
